// File: rtl/care_scheduler.sv
// Care-action scheduler: latches button presses, round-robin arbitrates them, clamps relief
// to the current stat level and issues one command per animation + cooldown window.
module care_scheduler #(
    parameter int AMOUNT          = 4,
    parameter int ANIM_CYCLES     = 13_500_000,
    parameter int COOLDOWN_CYCLES = 27_000_000,
    parameter int CNT_W           = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  req,
    input  logic [23:0] stat_levels,
    output logic        act_valid,
    output logic [2:0]  act_sel,
    output logic [3:0]  act_amount,
    input  logic        act_ready,
    output logic        busy,
    output logic [5:0]  grant,
    output logic        reject,
    output logic [5:0]  pending
);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, COOLDOWN} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       ptr, ptr_n;
    logic [5:0]       req_q;
    logic [5:0]       pending_n, clr;
    logic             act_valid_n, reject_n;
    logic [2:0]       act_sel_n;
    logic [3:0]       act_amount_n;
    logic [5:0]       grant_n;
    logic [2:0]       win;
    logic [3:0]       stat_w, clamp;

    // First set bit searching upward from p+1, wrapping 5 -> 0.
    function automatic logic [2:0] rr_pick(input logic [2:0] p, input logic [5:0] pend);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        idx     = p;
        for (int k = 0; k < 6; k++) begin
            idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            if (!found && pend[idx]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

    function automatic logic [3:0] stat_of(input logic [2:0] sel, input logic [23:0] s);
        case (sel)
            3'd1:    stat_of = s[7:4];
            3'd2:    stat_of = s[11:8];
            3'd3:    stat_of = s[15:12];
            3'd4:    stat_of = s[19:16];
            3'd5:    stat_of = s[23:20];
            default: stat_of = s[3:0];
        endcase
    endfunction

    assign win    = rr_pick(ptr, pending);
    assign stat_w = stat_of(win, stat_levels);
    assign clamp  = (stat_w < 4'(AMOUNT)) ? stat_w : 4'(AMOUNT);
    assign busy   = (state != IDLE);

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        ptr_n        = ptr;
        act_valid_n  = act_valid;
        act_sel_n    = act_sel;
        act_amount_n = act_amount;
        grant_n      = grant;
        reject_n     = 1'b0;
        clr          = 6'd0;

        case (state)
            IDLE: begin
                if (|pending) begin
                    ptr_n = win;
                    clr   = 6'd1 << win;
                    if (stat_w == 4'd0) begin
                        reject_n = 1'b1;
                    end else begin
                        act_valid_n  = 1'b1;
                        act_sel_n    = win;
                        act_amount_n = clamp;
                        grant_n      = 6'd1 << win;
                        state_n      = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (act_ready) begin
                    act_valid_n = 1'b0;
                    cnt_n       = CNT_W'(ANIM_CYCLES - 1);
                    state_n     = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    grant_n = 6'd0;
                    if (COOLDOWN_CYCLES != 0) begin
                        cnt_n   = CNT_W'(COOLDOWN_CYCLES - 1);
                        state_n = COOLDOWN;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            COOLDOWN: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // A new press of the same bit outranks the clear issued by the arbiter.
        pending_n = (pending & ~clr) | (req & ~req_q);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            ptr        <= 3'd5;
            req_q      <= 6'd0;
            pending    <= 6'd0;
            act_valid  <= 1'b0;
            act_sel    <= 3'd0;
            act_amount <= 4'd0;
            grant      <= 6'd0;
            reject     <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ptr        <= ptr_n;
            req_q      <= req;
            pending    <= pending_n;
            act_valid  <= act_valid_n;
            act_sel    <= act_sel_n;
            act_amount <= act_amount_n;
            grant      <= grant_n;
            reject     <= reject_n;
        end
    end

endmodule
